// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter sizing for the sequential divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DIV_N_DEFAULT = 32;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub: ripple subtractor a + ~b + 1 from full-adder cells; nonneg is the carry-out (a >= b).
module div_trial_sub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         nonneg
);
  logic [W:0] c;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign diff[i]  = a[i] ^ ~b[i] ^ c[i];
    assign c[i+1]   = (a[i] & ~b[i]) | (a[i] & c[i]) | (~b[i] & c[i]);
  end
  assign nonneg = c[W];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: N-cycle restoring divider with start/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating toward zero).
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = cnt_w(N);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [N:0] r, r_sh, diff, r_nx;
  logic [N-1:0] q, dvs, q_nx, a_mag, b_mag, q_fix, r_fix;
  logic nonneg, accept, dz;
  assign accept = start && state != RUN;
  assign dz     = divisor == '0;
  assign busy   = state == RUN;
  assign done   = state == DONE;
  assign r_sh   = {r[N-1:0], q[N-1]};
  div_trial_sub #(.W(N+1)) u_sub (.a(r_sh), .b({1'b0, dvs}), .diff(diff), .nonneg(nonneg));
  assign q_nx = {q[N-2:0], nonneg};
  assign r_nx = nonneg ? diff : r_sh;
`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q, neg_r;
  assign a_mag = dividend[N-1] ? -dividend : dividend;
  assign b_mag = divisor[N-1] ? -divisor : divisor;
  assign q_fix = neg_q ? -q_nx : q_nx;
  assign r_fix = neg_r ? -r_nx[N-1:0] : r_nx[N-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dividend[N-1] ^ divisor[N-1];
      neg_r <= dividend[N-1];
    end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fix = q_nx;
  assign r_fix = r_nx[N-1:0];
`endif
  always_comb begin
    state_nx = IDLE;
    if (accept) state_nx = dz ? DONE : RUN;
    else if (state == RUN) state_nx = (cnt == '0) ? DONE : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt         <= CW'(N - 1);
        r           <= '0;
        q           <= a_mag;
        dvs         <= b_mag;
        div_by_zero <= dz;
        if (dz) begin
          quotient  <= '1;
          remainder <= dividend;
        end
      end else if (state == RUN) begin
        r   <= r_nx;
        q   <= q_nx;
        cnt <= cnt - 1'b1;
        // results appear only on the final iteration, never as partial values
        if (cnt == '0) begin
          quotient  <= q_fix;
          remainder <= r_fix;
        end
      end
    end
endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned integer divider built on the team's subtract path.
- Each cycle it issues one trial subtraction of the divisor from the shifted partial remainder.
- It keeps the difference only when the result is non-negative, producing one quotient bit per cycle.
- Sits directly downstream of the operand/subtract datapath and feeds results to the register/writeback stage with a start/done handshake.

Parameters:
- N, 32, operand width in bits for dividend, divisor, quotient and remainder; legal range 2..64.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when the block is ready (see Behaviour).
- dividend  input  N  numerator; captured on an accepted start.
- divisor  input  N  denominator; captured on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  N  result quotient; held until the next accepted start.
- remainder  output  N  result remainder; held until the next accepted start.
- div_by_zero  output  1  set with done when divisor==0; held alongside results.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (any time, including mid-operation):
  - state=IDLE; busy, done, div_by_zero, quotient and remainder all 0.
  - Internal iteration counter and partial remainder are cleared.
  - No done pulse is produced for the aborted operation.
- States:
  - IDLE: ready. start=1 captures the operands.
    - divisor!=0 -> RUN, counter=N-1, partial remainder R (N+1 bits)=0, Q=dividend.
    - divisor==0 -> DONE directly.
  - RUN, each cycle:
    - {R,Q} shifted left by 1.
    - trial = R_shifted - {1'b0,divisor}, computed in N+1 bits; the MSB of trial is the borrow/sign.
    - Sign 0 -> R=trial and Q[0]=1; otherwise R is kept and Q[0]=0.
    - Counter decrements; when counter==0 -> DONE.
  - DONE: one cycle. done=1; quotient=Q, remainder=R[N-1:0]. Next state is IDLE.
    - start=1 while in DONE is accepted exactly as in IDLE, giving back-to-back operation with no bubble.
- busy is 1 in RUN; 0 in IDLE and DONE.
- start while busy=1 is ignored; it does not queue and does not corrupt the operation in flight.
- Latency:
  - Normal: accepted start at edge k -> done high in cycle k+N+1; exactly N RUN cycles.
  - Divide by zero: done high the cycle after the accepted start.
- Divide by zero: quotient = all ones; remainder = dividend; div_by_zero=1.
- div_by_zero clears on the next accepted start.
- Results register only on entry to DONE; outputs never show partial values.
- Edge cases:
  - dividend=0 -> quotient 0, remainder 0, full N-cycle latency.
  - divisor > dividend -> quotient 0, remainder = dividend.

Optional Feature:
- Macro SEQ_DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are formed at accept time via invert-plus-one.
  - Result signs are fixed up on entry to DONE: quotient is negated when the operand signs differ; remainder takes the dividend's sign.
  - Division truncates toward zero.
  - Latency is unchanged.
  - -2^(N-1)/-1 -> quotient = -2^(N-1) (wraps), remainder 0.
  - Divide by zero: quotient = all ones (-1), remainder = dividend.
- Undefined: unsigned-only operation exactly as described above; no sign logic is synthesised.

Decomposition:
- Shared package/include file `div_pkg` holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default width constant DIV_N_DEFAULT=32;
  - counter width function/constant clog2(N).
- Sub-module `div_trial_sub` (parameter W=N+1):
  - combinational W-bit ripple subtractor built from full-adder cells, computing a + ~b + 1;
  - outputs diff[W-1:0] and nonneg (= carry-out).
  - Instantiated once in the RUN datapath.

Test Plan:
- N=8, dividend=100, divisor=7, start one cycle -> busy high 8 cycles, done pulse 9 cycles after start, quotient=14, remainder=2, div_by_zero=0.
- N=8, dividend=55, divisor=0 -> done the next cycle, quotient=8'hFF, remainder=55, div_by_zero=1, busy never high.
- N=8, 200/3 started, then start=1 with 9/9 at RUN cycle 3 -> second request ignored; result quotient=66, remainder=2; exactly one done pulse.
- N=8, 255/1 started, rst_n low at RUN cycle 4 -> all outputs 0 immediately; no done; a fresh 9/4 then gives quotient=2, remainder=1.
- N=8, back-to-back: 100/7 then start held in the DONE cycle with 0/5 -> second done N+1 cycles later, quotient=0, remainder=0.
- SEQ_DIV_SIGNED_EN defined, N=8, -7/2 -> quotient=8'hFD (-3), remainder=8'hFF (-1); -128/-1 -> quotient=8'h80, remainder=0.
